// File: rtl/sim_ram_pkg.sv
// Shared definitions for the multi-read-port simulation RAM.
// The default word geometry is 4 bytes by 64 words. apply_be does byte-enable
// merging on a word wide enough for any supported width (up to MAX_BYTES).
// Callers zero-extend their operands and take back the low bits they need.
package sim_ram_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int WORD_ADDR_W = 6;
  localparam int DATA_WIDTH  = WORD_BYTES * 8;
  localparam int DEPTH       = 2 ** WORD_ADDR_W;

  localparam int MAX_BYTES   = 8;
  localparam int MAX_WIDTH   = MAX_BYTES * 8;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [WORD_BYTES-1:0] be_t;

  typedef logic [MAX_WIDTH-1:0]  wide_word_t;
  typedef logic [MAX_BYTES-1:0]  wide_be_t;

  // Byte b of the result comes from new_w when be[b] is set, else from old_w.
  function automatic wide_word_t apply_be(input wide_word_t old_w,
                                          input wide_word_t new_w,
                                          input wide_be_t   be);
    wide_word_t res;
    res = old_w;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sim_ram_rd_pipe.sv
// Read-latency pipeline for one read port of sim_ram_mp.
// The array word sampled on the request edge enters here. It leaves
// LATENCY clock edges later, counting the sampling edge itself.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_vld, in_data     request accepted this edge and the word sampled for it
//   out_vld, out_data   one-cycle valid pulse. out_data holds while out_vld is 0.
// Only the valid bits and the output register are reset. The intermediate data
// stages are free-running.
module sim_ram_rd_pipe
  import sim_ram_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic             tail_vld;
  logic [WIDTH-1:0] tail_data;

  if (LATENCY == 1) begin : g_direct
    assign tail_vld  = in_vld;
    assign tail_data = in_data;
  end else begin : g_shift
    logic [LATENCY-2:0] vld_p;
    logic [WIDTH-1:0]   data_p [LATENCY-1];

    // stages 0..LATENCY-2: delay line ahead of the output register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= in_vld;
        for (int k = 1; k < LATENCY - 1; k++) vld_p[k] <= vld_p[k-1];
      end
    end

    always_ff @(posedge clk) begin
      data_p[0] <= in_data;
      for (int k = 1; k < LATENCY - 1; k++) data_p[k] <= data_p[k-1];
    end

    assign tail_vld  = vld_p[LATENCY-2];
    assign tail_data = data_p[LATENCY-2];
  end

  // output stage: data loads only with a valid beat, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld <= tail_vld;
      if (tail_vld) out_data <= tail_data;
    end
  end

endmodule

// File: rtl/sim_ram_mp.sv
// Multi-read-port simulation RAM used as backing memory in block-level benches.
// It has one write port with byte enables and NUM_RD independent pipelined read
// ports with RD_LATENCY cycles of latency. A read and a write to the same address
// on the same edge return the merged new word when WR_FIRST=1, or the old word
// when WR_FIRST=0. The array is not reset. Reset clears the read pipelines only.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_en[NUM_RD]               per-port read request
//   rd_addr[NUM_RD*ADDR_WIDTH]  packed word addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data[NUM_RD*DW]          packed read data, held while the port is not valid
//   rd_valid[NUM_RD]            one-cycle pulse per accepted request
//   wr_en, wr_addr, wr_be, wr_data   byte-enabled write
module sim_ram_mp
  import sim_ram_pkg::*;
#(
  parameter int DATA_SIZE_BYTES = 4,
  parameter int ADDR_WIDTH      = 6,
  parameter int NUM_RD          = 2,
  parameter int RD_LATENCY      = 1,
  parameter bit WR_FIRST        = 1'b1,
  localparam int DW             = DATA_SIZE_BYTES * 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0]         rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_SIZE_BYTES-1:0]   wr_be,
  input  logic [DW-1:0]                wr_data
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $fatal(1, "sim_ram_mp: NUM_RD=%0d outside 1..4", NUM_RD);
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "sim_ram_mp: RD_LATENCY=%0d outside 1..4", RD_LATENCY);
  end
  if (DATA_SIZE_BYTES < 1 || DATA_SIZE_BYTES > MAX_BYTES) begin : g_bad_bytes
    $fatal(1, "sim_ram_mp: DATA_SIZE_BYTES=%0d outside 1..%0d", DATA_SIZE_BYTES, MAX_BYTES);
  end

  // Narrow wrapper around the package merge. Operands are zero-extended to the
  // package word width.
  function automatic logic [DW-1:0] merge_be(input logic [DW-1:0]              old_w,
                                             input logic [DW-1:0]              new_w,
                                             input logic [DATA_SIZE_BYTES-1:0] be);
    wide_word_t o, n, r;
    wide_be_t   e;
    o = '0;
    n = '0;
    e = '0;
    o[DW-1:0]              = old_w;
    n[DW-1:0]              = new_w;
    e[DATA_SIZE_BYTES-1:0] = be;
    r = apply_be(o, n, e);
    return r[DW-1:0];
  endfunction

  logic [DW-1:0] mem [MEM_DEPTH];
  logic [DW-1:0] wr_merged;

  // The same merged word feeds the array update and the write-first bypass.
  always_comb begin
    wr_merged = merge_be(mem[wr_addr], wr_data, wr_be);
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_addr] <= wr_merged;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  bypass_hit;
    logic [DW-1:0]         rd_word;

    assign rd_addr_i = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      bypass_hit = WR_FIRST && wr_en && (wr_addr == rd_addr_i);
      rd_word    = bypass_hit ? wr_merged : mem[rd_addr_i];
    end

    sim_ram_rd_pipe #(
      .WIDTH   (DW),
      .LATENCY (RD_LATENCY)
    ) u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (rd_en[i]),
      .in_data  (rd_word),
      .out_vld  (rd_valid[i]),
      .out_data (rd_data[i*DW +: DW])
    );
  end

  // An unknown address with its enable high is an assertion failure in sim.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst_n && rd_en[i]) begin
        assert (!$isunknown(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]))
          else $error("sim_ram_mp: X on rd_addr port %0d", i);
      end
    end
    if (rst_n && wr_en) begin
      assert (!$isunknown(wr_addr)) else $error("sim_ram_mp: X on wr_addr");
    end
  end

endmodule

// File: tb/tb_sim_ram_mp.sv
// Bench for sim_ram_mp. It drives two instances from the same stimulus:
//   dut_a: RD_LATENCY=3, WR_FIRST=1
//   dut_b: RD_LATENCY=1, WR_FIRST=0
// Inputs change just after a falling edge. Outputs are sampled on falling edges.
module tb_sim_ram_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [11:0] rd_addr;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sim_ram_mp #(
    .DATA_SIZE_BYTES (4), .ADDR_WIDTH (6), .NUM_RD (2),
    .RD_LATENCY (3), .WR_FIRST (1'b1)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data_a), .rd_valid (rd_valid_a), .wr_en (wr_en),
    .wr_addr (wr_addr), .wr_be (wr_be), .wr_data (wr_data)
  );

  sim_ram_mp #(
    .DATA_SIZE_BYTES (4), .ADDR_WIDTH (6), .NUM_RD (2),
    .RD_LATENCY (1), .WR_FIRST (1'b0)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data_b), .rd_valid (rd_valid_b), .wr_en (wr_en),
    .wr_addr (wr_addr), .wr_be (wr_be), .wr_data (wr_data)
  );

  typedef struct {
    bit          is_wr;
    int          port;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Issues one read cycle on the ports in en, optionally with a same-edge write.
  // Checks valid pulse timing on both instances and data for enabled ports.
  // On the cycle after each pulse it also checks that the data holds.
  task automatic read_txn(input logic [1:0] en, input logic [5:0] a0, input logic [5:0] a1,
                          input logic [31:0] ea0, input logic [31:0] ea1,
                          input logic [31:0] eb0, input logic [31:0] eb1,
                          input bit do_wr, input logic [5:0] wa, input logic [3:0] wbe,
                          input logic [31:0] wd, input string name);
    logic [31:0] ea [2];
    logic [31:0] eb [2];
    ea[0] = ea0; ea[1] = ea1; eb[0] = eb0; eb[1] = eb1;
    rd_en         = en;
    rd_addr[5:0]  = a0;
    rd_addr[11:6] = a1;
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = wa; wr_be = wbe; wr_data = wd;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rd_en = 2'b00;
        wr_en = 1'b0;
      end
      check($sformatf("%s vld_a k%0d", name, k), 64'(rd_valid_a), 64'((k == 3) ? en : 2'b00));
      check($sformatf("%s vld_b k%0d", name, k), 64'(rd_valid_b), 64'((k == 1) ? en : 2'b00));
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          if (k >= 3)
            check($sformatf("%s data_a p%0d k%0d", name, p, k), 64'(rd_data_a[p*32 +: 32]), 64'(ea[p]));
          if (k <= 2)
            check($sformatf("%s data_b p%0d k%0d", name, p, k), 64'(rd_data_b[p*32 +: 32]), 64'(eb[p]));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e0, e1;
    bit va, vb;
    int j;

    rst_n = 1'b0; rd_en = '0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;

    repeat (3) @(negedge clk);
    check("reset vld_a",  64'(rd_valid_a), 64'h0);
    check("reset data_a", rd_data_a,       64'h0);
    check("reset vld_b",  64'(rd_valid_b), 64'h0);
    check("reset data_b", rd_data_b,       64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0]  = '{1'b1, 0, 6'd5,  4'hF, 32'hDEADBEEF, 32'h0,        "w5"};
    tbl[1]  = '{1'b0, 0, 6'd5,  4'h0, 32'h0,        32'hDEADBEEF, "rd5_full"};
    tbl[2]  = '{1'b1, 0, 6'd3,  4'hF, 32'h11223344, 32'h0,        "w3"};
    tbl[3]  = '{1'b1, 0, 6'd3,  4'h5, 32'hAABBCCDD, 32'h0,        "w3_be5"};
    tbl[4]  = '{1'b0, 1, 6'd3,  4'h0, 32'h0,        32'h11BB33DD, "rd3_partial"};
    tbl[5]  = '{1'b1, 0, 6'd3,  4'h0, 32'hFFFFFFFF, 32'h0,        "w3_be0"};
    tbl[6]  = '{1'b0, 0, 6'd3,  4'h0, 32'h0,        32'h11BB33DD, "rd3_be0_noop"};
    tbl[7]  = '{1'b1, 0, 6'd10, 4'hF, 32'h01020304, 32'h0,        "w10"};
    tbl[8]  = '{1'b1, 0, 6'd10, 4'hA, 32'hCAFEBABE, 32'h0,        "w10_beA"};
    tbl[9]  = '{1'b0, 1, 6'd10, 4'h0, 32'h0,        32'hCA02BA04, "rd10_beA"};
    tbl[10] = '{1'b1, 0, 6'd63, 4'hF, 32'h0BADF00D, 32'h0,        "w63"};
    tbl[11] = '{1'b0, 0, 6'd63, 4'h0, 32'h0,        32'h0BADF00D, "rd63_p0"};

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        do_write(tbl[i].addr, tbl[i].be, tbl[i].data);
      end else if (tbl[i].port == 0) begin
        read_txn(2'b01, tbl[i].addr, 6'd0, tbl[i].exp, 32'h0, tbl[i].exp, 32'h0,
                 1'b0, 6'd0, 4'h0, 32'h0, tbl[i].name);
      end else begin
        read_txn(2'b10, 6'd0, tbl[i].addr, 32'h0, tbl[i].exp, 32'h0, tbl[i].exp,
                 1'b0, 6'd0, 4'h0, 32'h0, tbl[i].name);
      end
    end

    // Back-to-back reads: port 0 reads 0..7 and port 1 reads 7..0, one per cycle.
    for (int i = 0; i < 8; i++) do_write(6'(i), 4'hF, 32'hC0DE0000 + 32'(i));
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        rd_en = 2'b11;
        rd_addr[5:0]  = 6'(c);
        rd_addr[11:6] = 6'(7 - c);
      end else begin
        rd_en = 2'b00;
      end
      @(negedge clk);
      va = (c + 1 >= 3) && (c + 1 <= 10);
      vb = (c + 1 <= 8);
      check($sformatf("b2b vld_a k%0d", c + 1), 64'(rd_valid_a), va ? 64'h3 : 64'h0);
      check($sformatf("b2b vld_b k%0d", c + 1), 64'(rd_valid_b), vb ? 64'h3 : 64'h0);
      if (va) begin
        j  = c - 2;
        e0 = 32'hC0DE0000 + 32'(j);
        e1 = 32'hC0DE0000 + 32'(7 - j);
        check($sformatf("b2b data_a beat%0d", j), rd_data_a, {e1, e0});
      end
      if (vb) begin
        j  = c;
        e0 = 32'hC0DE0000 + 32'(j);
        e1 = 32'hC0DE0000 + 32'(7 - j);
        check($sformatf("b2b data_b beat%0d", j), rd_data_b, {e1, e0});
      end
    end

    // Read-during-write on the same address and edge.
    do_write(6'd9, 4'hF, 32'h12345678);
    read_txn(2'b01, 6'd9, 6'd0, 32'h00000000, 32'h0, 32'h12345678, 32'h0,
             1'b1, 6'd9, 4'hF, 32'h00000000, "rdw_full");
    read_txn(2'b01, 6'd9, 6'd0, 32'h0000AAAA, 32'h0, 32'h00000000, 32'h0,
             1'b1, 6'd9, 4'h3, 32'hFFFFAAAA, "rdw_partial");
    read_txn(2'b10, 6'd0, 6'd9, 32'h0, 32'h0000AAAA, 32'h0, 32'h0000AAAA,
             1'b0, 6'd0, 4'h0, 32'h0, "rdw_after");
    // Write to a different address on the same edge must not disturb the read.
    read_txn(2'b01, 6'd10, 6'd0, 32'hCA02BA04, 32'h0, 32'hCA02BA04, 32'h0,
             1'b1, 6'd11, 4'hF, 32'h55555555, "rdw_diff_addr");

    // Both ports read the top address in the same cycle.
    read_txn(2'b11, 6'd63, 6'd63, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D,
             1'b0, 6'd0, 4'h0, 32'h0, "rd63_both");

    // Reset while a latency-3 read is in flight.
    rd_en = 2'b01;
    rd_addr[5:0] = 6'd10;
    @(negedge clk);
    check("rst pre vld_b",  64'(rd_valid_b),      64'h1);
    check("rst pre data_b", 64'(rd_data_b[31:0]), 64'hCA02BA04);
    rst_n   = 1'b0;
    rd_en   = 2'b11;
    wr_en   = 1'b1;
    wr_addr = 6'd10;
    wr_be   = 4'hF;
    wr_data = 32'hFFFFFFFF;
    #1;
    check("rst async vld_a",  64'(rd_valid_a), 64'h0);
    check("rst async data_a", rd_data_a,       64'h0);
    check("rst async vld_b",  64'(rd_valid_b), 64'h0);
    check("rst async data_b", rd_data_b,       64'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst held vld_a c%0d", c), 64'(rd_valid_a), 64'h0);
      check($sformatf("rst held vld_b c%0d", c), 64'(rd_valid_b), 64'h0);
    end
    rst_n = 1'b1;
    rd_en = 2'b00;
    wr_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("post rst vld_a c%0d", c), 64'(rd_valid_a), 64'h0);
      check($sformatf("post rst vld_b c%0d", c), 64'(rd_valid_b), 64'h0);
    end
    read_txn(2'b01, 6'd10, 6'd0, 32'hCA02BA04, 32'h0, 32'hCA02BA04, 32'h0,
             1'b0, 6'd0, 4'h0, 32'h0, "preserved10");
    read_txn(2'b10, 6'd0, 6'd3, 32'h0, 32'hC0DE0003, 32'h0, 32'hC0DE0003,
             1'b0, 6'd0, 4'h0, 32'h0, "preserved3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
